// File: rtl/vjtag_cmd_pkg.sv
// Shared constants, command classes and width helpers for the vJTAG command register.
package vjtag_cmd_pkg;

  // vJTAG instruction codes seen on ir_in
  localparam int IR_BYPASS = 0;
  localparam int IR_WRITE  = 1;
  localparam int IR_READ   = 2;

  // Fixed opcodes; channel writes use 1..N_CH
  localparam int OPC_NOP   = 0;
  localparam int OPC_RDSEL = 14;
  localparam int OPC_CLEAR = 15;

  // Error counter width and its saturation value
  localparam int ERR_CNT_W = 8;

  // Decoded meaning of a captured frame
  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_WRITE,
    CMD_RDSEL,
    CMD_CLEAR,
    CMD_REJECT
  } cmd_e;

  // Full DR length: opcode in the MSBs, payload in the LSBs
  function automatic int dr_width(input int opc_w, input int pay_w);
    return opc_w + pay_w;
  endfunction

  // Bit counter is one bit wider than needed for DR_W so over-long frames
  // stay distinguishable from exact-length frames until it saturates
  function automatic int bitcnt_width(input int dr_w);
    return $clog2(dr_w) + 1;
  endfunction

  // Width of the readback channel selector, at least one bit
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Readback layout: {err_sticky, rd_sel zero-extended, ch_data[rd_sel]}
  function automatic int rb_err_bit(input int opc_w, input int pay_w);
    return opc_w + pay_w - 1;
  endfunction

  function automatic int rb_sel_w(input int opc_w);
    return opc_w - 1;
  endfunction

endpackage

// File: rtl/vjtag_shift_ctl.sv
// DR shift register, frame bit counter, bypass flop and tdo mux for the vJTAG port.
module vjtag_shift_ctl
  import vjtag_cmd_pkg::*;
#(
  parameter int IR_W = 2,
  parameter int DR_W = 32
) (
  input  logic            tck,
  input  logic            aclr,
  input  logic [IR_W-1:0] ir_in,
  input  logic            tdi,
  input  logic            st_cdr,
  input  logic            st_sdr,
  input  logic            st_udr,
  input  logic [DR_W-1:0] rd_word,
  output logic            tdo,
  output logic [DR_W-1:0] sr,
  output logic            frame_ok
);

  localparam int BCW = bitcnt_width(DR_W);
  localparam logic [BCW-1:0] BC_MAX = '1;

  logic [BCW-1:0] bitcnt;
  logic           byp;
  logic           is_byp;
  logic           is_write;
  logic           is_read;

  assign is_byp   = (ir_in == IR_W'(IR_BYPASS));
  assign is_write = (ir_in == IR_W'(IR_WRITE));
  assign is_read  = (ir_in == IR_W'(IR_READ));

  // A frame is well-formed only when exactly DR_W bits were shifted since capture
  assign frame_ok = (bitcnt == BCW'(DR_W));

  // Capture/shift state; update cycles take priority and leave the shifter alone
  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      sr     <= '0;
      bitcnt <= '0;
      byp    <= 1'b0;
    end else if (!st_udr) begin
      if (st_cdr) begin
        if (is_write) begin
          sr     <= '0;
          bitcnt <= '0;
        end else if (is_read) begin
          sr     <= rd_word;
          bitcnt <= '0;
        end
      end else if (st_sdr) begin
        if (is_write || is_read) begin
          sr <= {tdi, sr[DR_W-1:1]};
          if (bitcnt != BC_MAX) begin
            bitcnt <= bitcnt + 1'b1;
          end
        end else if (is_byp) begin
          byp <= tdi;
        end
      end
    end
  end

  // tdo follows the register selected by the current instruction
  always_comb begin
    tdo = 1'b0;
    if (is_byp) begin
      tdo = byp;
    end else if (is_write || is_read) begin
      tdo = sr[0];
    end
  end

endmodule

// File: rtl/vjtag_cmd_decoder.sv
// vJTAG command register: frame decode, channel register file, readback select and error tracking.
module vjtag_cmd_decoder
  import vjtag_cmd_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int PAY_W = 28,
  parameter int N_CH  = 4,
  parameter int IR_W  = 2,
  parameter int LED_W = 10
) (
  input  logic                  tck,
  input  logic                  aclr,
  input  logic [IR_W-1:0]       ir_in,
  input  logic                  tdi,
  input  logic                  st_cdr,
  input  logic                  st_sdr,
  input  logic                  st_udr,
  output logic                  tdo,
  output logic [N_CH*PAY_W-1:0] ch_data,
  output logic [N_CH-1:0]       ch_valid,
  output logic [N_CH-1:0]       upd_toggle,
  output logic [N_CH-1:0]       mode,
  output logic [LED_W-1:0]      led,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int DR_W     = dr_width(OPC_W, PAY_W);
  localparam int SEL_W    = sel_width(N_CH);
  localparam int RB_SEL_W = rb_sel_w(OPC_W);

  logic [DR_W-1:0]  sr;
  logic [DR_W-1:0]  rd_word;
  logic             frame_ok;
  logic             armed;
  logic [SEL_W-1:0] rd_sel;
  logic [PAY_W-1:0] ch_reg [N_CH];

  logic             is_write;
  logic             cmd_fire;
  logic [OPC_W-1:0] opc;
  logic [PAY_W-1:0] pay;
  cmd_e             cmd;
  logic [N_CH-1:0]  wr_onehot;

  assign is_write = (ir_in == IR_W'(IR_WRITE));
  assign cmd_fire = st_udr && is_write && armed;
  assign opc      = sr[DR_W-1:PAY_W];
  assign pay      = sr[PAY_W-1:0];

  // Readback word loaded into the shifter on a READ capture
  always_comb begin
    rd_word                          = '0;
    rd_word[rb_err_bit(OPC_W, PAY_W)] = err_sticky;
    rd_word[PAY_W +: RB_SEL_W]       = RB_SEL_W'(rd_sel);
    rd_word[PAY_W-1:0]               = ch_reg[rd_sel];
  end

  vjtag_shift_ctl #(
    .IR_W (IR_W),
    .DR_W (DR_W)
  ) u_shift (
    .tck      (tck),
    .aclr     (aclr),
    .ir_in    (ir_in),
    .tdi      (tdi),
    .st_cdr   (st_cdr),
    .st_sdr   (st_sdr),
    .st_udr   (st_udr),
    .rd_word  (rd_word),
    .tdo      (tdo),
    .sr       (sr),
    .frame_ok (frame_ok)
  );

  // Flatten the register file onto the ch_data bus, ch0 in the LSBs
  for (genvar k = 0; k < N_CH; k++) begin : g_ch_out
    assign ch_data[k*PAY_W +: PAY_W] = ch_reg[k];
  end

  // Classify the captured frame; a wrong bit count overrides any opcode.
  // RDSEL compares the whole payload so an out-of-range channel number is
  // rejected rather than silently aliased onto a valid one.
  always_comb begin
    cmd       = CMD_REJECT;
    wr_onehot = '0;
    if (opc == OPC_W'(OPC_NOP)) begin
      cmd = CMD_NOP;
    end else if (opc == OPC_W'(OPC_RDSEL)) begin
      if (pay < PAY_W'(N_CH)) begin
        cmd = CMD_RDSEL;
      end
    end else if (opc == OPC_W'(OPC_CLEAR)) begin
      cmd = CMD_CLEAR;
    end else if (int'(opc) <= N_CH) begin
      cmd       = CMD_WRITE;
      wr_onehot = N_CH'(1) << (opc - OPC_W'(1));
    end
    if (!frame_ok) begin
      cmd       = CMD_REJECT;
      wr_onehot = '0;
    end
  end

  // A WRITE capture arms exactly one update; update consumes it
  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      armed <= 1'b0;
    end else if (st_udr) begin
      if (is_write && armed) begin
        armed <= 1'b0;
      end
    end else if (st_cdr && is_write) begin
      armed <= 1'b1;
    end
  end

  // Channel register file plus the per-write side outputs
  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < N_CH; k++) begin
        ch_reg[k] <= '0;
      end
      ch_valid   <= '0;
      upd_toggle <= '0;
      mode       <= '0;
      led        <= '0;
    end else if (cmd_fire) begin
      if (cmd == CMD_WRITE) begin
        for (int k = 0; k < N_CH; k++) begin
          if (wr_onehot[k]) begin
            ch_reg[k]     <= pay;
            ch_valid[k]   <= 1'b1;
            upd_toggle[k] <= ~upd_toggle[k];
          end
        end
        mode <= wr_onehot;
        led  <= pay[LED_W-1:0];
      end else if (cmd == CMD_CLEAR) begin
        for (int k = 0; k < N_CH; k++) begin
          ch_reg[k] <= '0;
        end
        ch_valid <= '0;
        mode     <= '0;
        led      <= '0;
      end
    end
  end

  // Readback channel selector
  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      rd_sel <= '0;
    end else if (cmd_fire && (cmd == CMD_RDSEL)) begin
      rd_sel <= pay[SEL_W-1:0];
    end
  end

  // Rejected frames set the sticky flag and bump a saturating counter
  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (cmd_fire && (cmd == CMD_REJECT)) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
